ram_fifo_ctrl: RTL and testbench

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_pkg.sv | 18 +
 rtl/ram_fifo_ctrl.sv | 137 +++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared defaults and FSM state encoding for the RAM-backed FIFO controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_SIZE   = 1 << DEF_ADDR_W;

  // IDLE: nothing held or in flight; FETCH: RAM read issued last cycle;
  // HOLD: out_data carries the head entry.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller using an external single-port synchronous RAM as storage.
// Latency: a write into an empty FIFO shows out_valid three cycles later; one bubble per pop.
// Backpressure: in_ready drops when storage is full or when a read fetch owns the RAM port.
module ram_fifo_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int SIZE   = DEF_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0]   SIZE_C   = (ADDR_W+1)'(SIZE);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(SIZE - 1);

  fifo_state_e       state_q;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   mem_count_q, mem_count_d;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;

  logic              pop;
  logic              fetch_issue;
  logic              wr_accept;
  logic              mem_full;
  logic              mem_nonempty;
  logic [ADDR_W:0]   count_w;

  // Pointers wrap at SIZE-1 so non-power-of-two depths still work.
  function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : (p + PTR_ONE);
  endfunction

  // Handshake decode: a fetch always has priority over a write for the RAM port.
  always_comb begin
    pop          = out_valid_q && out_ready;
    mem_nonempty = (mem_count_q != '0);
    mem_full     = (mem_count_q == SIZE_C);
    fetch_issue  = !rst && mem_nonempty &&
                   ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && pop));
    in_ready     = !rst && !mem_full && !fetch_issue;
    wr_accept    = in_valid && in_ready;
  end

  // RAM port mux: read address while fetching, otherwise the write pointer.
  always_comb begin
    ram_we    = wr_accept;
    ram_addr  = fetch_issue ? rd_ptr_q : wr_ptr_q;
    ram_wdata = in_data;
  end

  // Next-state for pointers and the RAM occupancy counter.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_count_d = mem_count_q;
    if (wr_accept) begin
      wr_ptr_d    = ptr_next(wr_ptr_q);
      mem_count_d = mem_count_q + CNT_ONE;
    end else if (fetch_issue) begin
      rd_ptr_d    = ptr_next(rd_ptr_q);
      mem_count_d = mem_count_q - CNT_ONE;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
    end
  end

  // Output FSM: capture read data one cycle after a fetch and hold it until popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fetch_issue) state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          out_data_q  <= ram_rdata;
          out_valid_q <= 1'b1;
          state_q     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (pop) begin
            out_valid_q <= 1'b0;
            state_q     <= fetch_issue ? ST_FETCH : ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  // Occupancy includes the in-flight fetch and the held head entry.
  always_comb begin
    count_w   = mem_count_q + (ADDR_W+1)'(state_q == ST_FETCH) + (ADDR_W+1)'(out_valid_q);
    count     = rst ? '0 : count_w;
    full      = !rst && mem_full;
    empty     = rst || (count_w == '0);
    out_valid = out_valid_q;
    out_data  = out_data_q;
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural single-port RAM and FIFO reference model.
// Latency: n/a.
// Backpressure: random and directed in_valid/out_ready patterns.
module tb_ram_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int SZ = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [AW:0]   count;
  logic          full;
  logic          empty;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW), .SIZE(SZ)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Single-port synchronous RAM sharing the controller's reset.
  logic [DW-1:0] ram_mem [0:SZ-1];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SZ; i++) ram_mem[i] <= '0;
      ram_rdata <= '0;
    end else if (ram_we) begin
      ram_mem[ram_addr] <= ram_wdata;
    end else begin
      ram_rdata <= ram_mem[ram_addr];
    end
  end

  // Reference model: entries in storage, one in-flight fetch, one held head,
  // plus a plain list of everything accepted for end-to-end order checking.
  logic [DW-1:0] m_mem[$];
  logic [DW-1:0] m_log[$];
  bit            m_pend;
  logic [DW-1:0] m_pend_d;
  bit            m_hv;
  logic [DW-1:0] m_hd;
  int            m_wr_n;
  int            m_rd_n;
  bit            last_acc;
  int            n_popped;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, predict, compare, advance model and clock.
  task automatic step(input bit r, input bit iv, input logic [DW-1:0] d, input bit ordy);
    bit idle, pop, fetch, exp_rdy, acc;
    int cnt;
    rst = r; in_valid = iv; in_data = d; out_ready = ordy;
    #2;
    idle    = !m_hv && !m_pend;
    pop     = m_hv && ordy;
    fetch   = !r && (m_mem.size() > 0) && (idle || pop);
    exp_rdy = !r && (m_mem.size() < SZ) && !fetch;
    acc     = iv && exp_rdy;
    cnt     = r ? 0 : m_mem.size() + int'(m_pend) + int'(m_hv);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("ram_we",   32'(ram_we),   32'(acc));
    if (fetch)       check("rd_addr", 32'(ram_addr), 32'(m_rd_n % SZ));
    else if (!r)     check("wr_addr", 32'(ram_addr), 32'(m_wr_n % SZ));
    if (acc)         check("ram_wdata", 32'(ram_wdata), 32'(d));
    check("count", 32'(count), 32'(cnt));
    check("full",  32'(full),  32'(!r && m_mem.size() == SZ));
    check("empty", 32'(empty), 32'(cnt == 0));
    if (!r) begin
      check("out_valid", 32'(out_valid), 32'(m_hv));
      if (m_hv) check("out_data", 32'(out_data), 32'(m_hd));
      if (pop) begin
        if (m_log.size() == 0) check("order_underflow", 32'(1), 32'(0));
        else check("order", 32'(out_data), 32'(m_log.pop_front()));
        n_popped++;
      end
    end
    last_acc = acc;
    if (r) begin
      m_mem.delete(); m_log.delete();
      m_pend = 0; m_hv = 0; m_hd = '0; m_wr_n = 0; m_rd_n = 0;
    end else begin
      if (acc) begin
        m_mem.push_back(d); m_log.push_back(d); m_wr_n++;
      end
      if (m_pend) begin
        m_hv = 1; m_hd = m_pend_d;
      end else if (pop) begin
        m_hv = 0;
      end
      m_pend = fetch;
      if (fetch) begin
        m_pend_d = m_mem.pop_front(); m_rd_n++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Hold a write until accepted, with a bounded number of attempts.
  task automatic push(input logic [DW-1:0] d, input bit ordy);
    int tries = 0;
    do begin
      step(0, 1, d, ordy);
      tries++;
    end while (!last_acc && tries < 20);
    if (!last_acc) check("push_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_reset();
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_data = '0; out_ready = 0;
    m_pend = 0; m_hv = 0; m_hd = '0; m_pend_d = '0;
    m_wr_n = 0; m_rd_n = 0; last_acc = 0; n_popped = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Reset state with inputs quiet.
    rst = 0; in_valid = 0; out_ready = 0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data",  32'(out_data),  32'(0));
    check("rst_count",     32'(count),     32'(0));
    check("rst_empty",     32'(empty),     32'(1));

    // Single write latency: head visible three cycles after acceptance.
    step(0, 1, 8'h11, 0);
    check("lat_acc", 32'(last_acc), 32'(1));
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    check("lat_valid", 32'(out_valid), 32'(1));
    check("lat_data",  32'(out_data),  32'(8'h11));
    check("lat_count", 32'(count),     32'(1));

    // Fill to capacity, confirm stall, then drain in order.
    do_reset();
    for (int v = 1; v <= 9; v++) push(8'(v), 0);
    step(0, 0, '0, 0);
    check("fill_full",  32'(full),  32'(1));
    check("fill_count", 32'(count), 32'(9));
    for (int i = 0; i < 4; i++) step(0, 1, 8'h0A, 0);
    check("fill_stall", 32'(last_acc), 32'(0));
    for (int i = 0; i < 24 && m_log.size() > 0; i++) step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    check("drain_empty", 32'(empty), 32'(1));

    // Random stream across pointer wrap.
    do_reset();
    n_popped = 0;
    for (int i = 0; i < 400; i++)
      step(0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 40; i++) step(0, 0, '0, 1);
    check("stream_drained", 32'(m_log.size()), 32'(0));
    check("stream_min", 32'(n_popped >= 20), 32'(1));

    // Reset during a fetch discards everything queued.
    do_reset();
    for (int v = 0; v < 4; v++) push(8'h40 + 8'(v), 0);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 0);
    step(0, 0, '0, 1);
    check("pre_rst_fetch", 32'(m_pend), 32'(1));
    step(1, 0, '0, 0);
    rst = 0; out_ready = 0;
    #1;
    check("post_rst_valid", 32'(out_valid), 32'(0));
    check("post_rst_count", 32'(count),     32'(0));
    check("post_rst_empty", 32'(empty),     32'(1));
    push(8'hAA, 0);
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    check("aa_valid", 32'(out_valid), 32'(1));
    check("aa_data",  32'(out_data),  32'(8'hAA));

    // Pop and write in the same cycle: fetch wins, write lands next cycle.
    do_reset();
    push(8'h21, 0);
    push(8'h22, 0);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 0);
    rst = 0; in_valid = 1; in_data = 8'h33; out_ready = 1;
    #1;
    check("popwr_rdy", 32'(in_ready), 32'(0));
    step(0, 1, 8'h33, 1);
    step(0, 1, 8'h33, 0);
    check("popwr_next_acc", 32'(last_acc), 32'(1));
    for (int i = 0; i < 12; i++) step(0, 0, '0, 1);
    check("popwr_drained", 32'(m_log.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
